// File: rtl/uart_tx_arb_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
// Frame timing is derived here so the top and any reuse agree on widths.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2
  } state_e;

  localparam int DEF_NREQ         = 4;
  localparam int DEF_CLKS_PER_BIT = 5208;
  localparam int DEF_FRAME_BITS   = 12;
  localparam int DEF_STROBE_LEN   = 4;

  function automatic int frame_cycles(input int clks_per_bit, input int frame_bits);
    return clks_per_bit * frame_bits;
  endfunction

  function automatic int cnt_width(input int frame_cyc);
    return (frame_cyc > 1) ? $clog2(frame_cyc) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotating-priority picker: the first asserted request at or
// after ptr_i (wrapping modulo NREQ) wins.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic                    valid_o,
  output logic [$clog2(NREQ)-1:0] winner_o
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  // NOTE: every signal driven here gets a default before the loop, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NREQ)) begin
        sum = sum - (IDX_W+1)'(NREQ);
      end
      idx = sum[IDX_W-1:0];
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NREQ byte sources: round-robin grant,
// start strobe for the transmitter's edge detector, then a full-frame hold-off.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ         = DEF_NREQ,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FRAME_BITS   = DEF_FRAME_BITS,
  parameter int STROBE_LEN   = DEF_STROBE_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         ack,
  output logic [7:0]              tx_data,
  output logic                    tx_int,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int FRAME_CYCLES = frame_cycles(CLKS_PER_BIT, FRAME_BITS);
  localparam int CNT_W        = cnt_width(FRAME_CYCLES);
  localparam int IDX_W        = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [NREQ-1:0]  ack_q, ack_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_winner;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .valid_o  (pick_valid),
    .winner_o (pick_winner)
  );

  // Requests are only looked at in IDLE; pending levels wait for the next IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    ack_d     = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d            = STROBE;
          cnt_d              = '0;
          tx_data_d          = req_data[{pick_winner, 3'b000} +: 8];
          grant_d            = pick_winner;
          ack_d[pick_winner] = 1'b1;
          ptr_d              = (pick_winner == IDX_W'(NREQ-1)) ? '0 : pick_winner + 1'b1;
        end
      end
      STROBE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(STROBE_LEN-1)) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(FRAME_CYCLES-1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, matching the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      tx_data_q <= '0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      ack_q     <= ack_d;
    end
  end

  // busy and tx_int decode straight from state, so reset drops them at once.
  assign busy     = (state_q != IDLE);
  assign tx_int   = (state_q == STROBE);
  assign ack      = ack_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;

  a_ack_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
  a_ack_strobe : assert property (@(posedge clk) disable iff (rst) (ack != '0) |-> tx_int);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a frame-timing model predicts every
// grant; a monitor compares acks, busy, tx_int, tx_data and grant_id each cycle.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int CPB  = 4;
  localparam int FB   = 12;
  localparam int SL   = 4;
  localparam int FC   = CPB * FB;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic [7:0]        tx_data;
  logic              tx_int;
  logic              busy;
  logic [1:0]        grant_id;

  uart_tx_arbiter #(
    .NREQ         (NREQ),
    .CLKS_PER_BIT (CPB),
    .FRAME_BITS   (FB),
    .STROBE_LEN   (SL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .tx_data  (tx_data),
    .tx_int   (tx_int),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         src;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  typedef struct {
    int src;
    int cyc;
  } log_t;

  exp_t exp_q[$];
  log_t glog[$];

  int total = 0;
  int bad   = 0;

  // Stimulus state (what the sources drive next)
  logic            rst_v;
  logic [NREQ-1:0] req_v;
  logic [7:0]      data_v[NREQ];
  logic [NREQ-1:0] sticky;
  int              pend_src = -1;

  // Reference model: frame-level timing, not RTL structure
  int         m_ptr  = 0;
  int         m_free = 0;
  bit         m_has  = 0;
  int         m_g    = 0;
  logic [7:0] m_txd  = '0;
  int         m_gid  = 0;

  int busy_cnt = 0;
  int tx_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Drive inputs for the coming edge and predict what that edge does.
  task automatic apply();
    int k;
    int w;
    rst = rst_v;
    req = req_v;
    for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = data_v[i];
    k = cyc + 1;
    if (rst_v) begin
      m_ptr    = 0;
      m_free   = k + 1;
      m_has    = 0;
      m_txd    = '0;
      m_gid    = 0;
      pend_src = -1;
    end else if (k >= m_free && req_v != '0) begin
      w = -1;
      for (int j = 0; j < NREQ; j++) begin
        if (w < 0 && req_v[(m_ptr + j) % NREQ]) w = (m_ptr + j) % NREQ;
      end
      exp_q.push_back('{src: w, data: data_v[w], cyc: k});
      m_ptr    = (w + 1) % NREQ;
      m_free   = k + FC + 1;
      m_has    = 1;
      m_g      = k;
      m_txd    = data_v[w];
      m_gid    = w;
      pend_src = w;
    end
  endtask

  // One clock: apply, then at the next negedge the acked source reacts.
  task automatic cycle();
    apply();
    @(negedge clk);
    if (pend_src >= 0) begin
      if (sticky[pend_src]) data_v[pend_src] = 8'($urandom);
      else req_v[pend_src] = 1'b0;
      pend_src = -1;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst_v  = 1'b1;
    req_v  = '0;
    sticky = '0;
    cycle();
    rst_v = 1'b0;
    glog.delete();
    busy_cnt = 0;
    tx_cnt   = 0;
  endtask

  // Monitor: pops expectations whenever the DUT acks, checks levels every cycle
  initial begin
    int   c;
    int   src;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      c = cyc;
      if (busy)   busy_cnt++;
      if (tx_int) tx_cnt++;
      check("busy",     busy,     (m_has && c >= m_g && c <= m_g + FC - 1));
      check("tx_int",   tx_int,   (m_has && c >= m_g && c <= m_g + SL - 1));
      check("tx_data",  tx_data,  m_txd);
      check("grant_id", grant_id, m_gid);
      if (ack != '0) begin
        src = -1;
        for (int i = 0; i < NREQ; i++) if (ack[i] && src < 0) src = i;
        glog.push_back('{src: src, cyc: c});
        if (exp_q.size() == 0) begin
          check("unexpected_ack", ack, '0);
        end else begin
          e = exp_q.pop_front();
          check("ack_vec",   ack,      32'(1) << e.src);
          check("ack_cycle", c,        e.cyc);
          check("ack_data",  tx_data,  e.data);
          check("ack_gid",   grant_id, e.src);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= c) begin
        e = exp_q.pop_front();
        check("ack_missing", ack, 32'(1) << e.src);
      end
    end
  end

  initial begin
    rst_v  = 1'b1;
    req_v  = '0;
    sticky = '0;
    for (int i = 0; i < NREQ; i++) data_v[i] = '0;

    // Reset state
    do_reset();
    check("rst_ack", ack, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_int", tx_int, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_grant_id", grant_id, 2'd0);

    // 1: single request
    req_v     = 4'b0001;
    data_v[0] = 8'h41;
    run(60);
    check("t1_grants", glog.size(), 1);
    if (glog.size() >= 1) check("t1_src", glog[0].src, 0);
    check("t1_busy_len", busy_cnt, FC);
    check("t1_strobe_len", tx_cnt, SL);
    check("t1_data", tx_data, 8'h41);

    // 2: all four request together after reset
    do_reset();
    req_v = 4'b1111;
    for (int i = 0; i < NREQ; i++) data_v[i] = 8'h10 + 8'(i);
    run(4 * (FC + 1) + 10);
    check("t2_grants", glog.size(), 4);
    for (int i = 0; i < glog.size(); i++) check("t2_order", glog[i].src, i);
    for (int i = 1; i < glog.size(); i++) check("t2_period", glog[i].cyc - glog[i-1].cyc, FC + 1);
    check("t2_last_data", tx_data, 8'h13);

    // 3: fairness with two permanent requesters
    do_reset();
    sticky = 4'b0101;
    req_v  = 4'b0101;
    run(4 * (FC + 1) + 5);
    check("t3_grants", glog.size(), 5);
    for (int i = 0; i < glog.size(); i++) check("t3_alternate", glog[i].src, (i % 2) * 2);

    // 4: data changes during WAIT do not reach tx_data
    do_reset();
    data_v[0] = 8'h55;
    req_v     = 4'b0001;
    run(20);
    data_v[0] = 8'hAA;
    run(20);
    check("t4_hold_wait", tx_data, 8'h55);
    run(15);
    check("t4_hold_idle", tx_data, 8'h55);
    check("t4_grants", glog.size(), 1);

    // 5: late arrival waits for the frame to end
    do_reset();
    data_v[0] = 8'h31;
    data_v[3] = 8'h77;
    req_v     = 4'b0001;
    run(20);
    req_v[3] = 1'b1;
    run(25);
    check("t5_no_early_ack", glog.size(), 1);
    run(10);
    check("t5_grants", glog.size(), 2);
    if (glog.size() >= 2) begin
      check("t5_src", glog[1].src, 3);
      check("t5_gap", glog[1].cyc - glog[0].cyc, FC + 1);
    end

    // 6: reset mid-frame, then pointer restarts at 0
    do_reset();
    data_v[0] = 8'h01;
    req_v     = 4'b0001;
    run(21);
    rst_v = 1'b1;
    req_v = '0;
    cycle();
    check("t6_busy", busy, 1'b0);
    check("t6_tx_int", tx_int, 1'b0);
    check("t6_ack", ack, '0);
    rst_v = 1'b0;
    glog.delete();
    data_v[1] = 8'h61;
    data_v[3] = 8'h63;
    req_v     = 4'b1010;
    run(3);
    check("t6_grants", glog.size(), 1);
    if (glog.size() >= 1) check("t6_first", glog[0].src, 1);

    // Random traffic with withdrawals, data churn and occasional reset
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_v[i] && $urandom_range(0, 7) == 0) begin
          req_v[i]  = 1'b1;
          data_v[i] = 8'($urandom);
        end else if (req_v[i] && !sticky[i] && $urandom_range(0, 63) == 0) begin
          req_v[i] = 1'b0;
        end
        if ($urandom_range(0, 15) == 0) data_v[i] = 8'($urandom);
        if ($urandom_range(0, 99) == 0) sticky[i] = ~sticky[i];
      end
      rst_v = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst_v  = 1'b0;
    req_v  = '0;
    sticky = '0;
    run(FC + 10);
    check("drain_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
